mem_port_arbiter: RTL and testbench



---
 rtl/mem_port_arbiter.sv | 71 +++++++
 tb/tb_mem_port_arbiter.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin two-master memory port arbiter with bounded bursts; ports m0_*/m1_* master req/gnt/read return, mem_* shared memory port, owner = current bus owner
module mem_port_arbiter #(
  parameter int DATA = 32,
  parameter int ADDR = 32,
  parameter int MAX_BURST = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            m0_req,
  input  logic            m0_we,
  input  logic [ADDR-1:0] m0_addr,
  input  logic [DATA-1:0] m0_wdata,
  output logic            m0_gnt,
  output logic            m0_rvalid,
  output logic [DATA-1:0] m0_rdata,
  input  logic            m1_req,
  input  logic            m1_we,
  input  logic [ADDR-1:0] m1_addr,
  input  logic [DATA-1:0] m1_wdata,
  output logic            m1_gnt,
  output logic            m1_rvalid,
  output logic [DATA-1:0] m1_rdata,
  output logic            mem_we,
  output logic [ADDR-1:0] mem_addr,
  output logic [DATA-1:0] mem_wd,
  input  logic [DATA-1:0] mem_rd,
  output logic [1:0]      owner
);
  localparam int CW = $clog2(MAX_BURST + 1);
  typedef enum logic [1:0] {IDLE = 2'b00, OWN0 = 2'b01, OWN1 = 2'b10} state_t;
  state_t state;
  logic last_owner;
  logic [CW-1:0] beat_cnt, cnt_inc;
  logic own_req, oth_req, leave;
  always_comb begin
    own_req = state == OWN1 ? m1_req : m0_req;
    oth_req = state == OWN1 ? m0_req : m1_req;
    cnt_inc = beat_cnt == CW'(MAX_BURST) ? beat_cnt : beat_cnt + CW'(1);
    leave = !own_req || (oth_req && cnt_inc == CW'(MAX_BURST));
    m0_gnt = state == OWN0 && m0_req;
    m1_gnt = state == OWN1 && m1_req;
    mem_we = (m0_gnt && m0_we) || (m1_gnt && m1_we);
    mem_addr = state == OWN1 ? m1_addr : m0_addr;
    mem_wd = state == OWN1 ? m1_wdata : m0_wdata;
    owner = state;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      last_owner <= 1'b1;
      beat_cnt <= '0;
      m0_rvalid <= 1'b0;
      m1_rvalid <= 1'b0;
      m0_rdata <= '0;
      m1_rdata <= '0;
    end else begin
      m0_rvalid <= m0_gnt && !m0_we;
      m1_rvalid <= m1_gnt && !m1_we;
      if (m0_gnt && !m0_we) m0_rdata <= mem_rd;
      if (m1_gnt && !m1_we) m1_rdata <= mem_rd;
      if (state == IDLE) begin
        beat_cnt <= '0;
        if (m0_req && (!m1_req || last_owner)) state <= OWN0;
        else if (m1_req) state <= OWN1;
      end else if (leave) begin
        beat_cnt <= '0;
        last_owner <= state == OWN1;
        state <= !oth_req ? IDLE : state == OWN0 ? OWN1 : OWN0;
      end else beat_cnt <= cnt_inc;
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: scoreboarded bench for mem_port_arbiter (MAX_BURST=8 main instance, MAX_BURST=1 alternation instance)
module tb_mem_port_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic m0_req = 1'b0, m0_we = 1'b0, m1_req = 1'b0, m1_we = 1'b0;
  logic [31:0] m0_addr = '0, m0_wdata = '0, m1_addr = '0, m1_wdata = '0;
  logic m0_gnt, m0_rvalid, m1_gnt, m1_rvalid, mem_we;
  logic [31:0] m0_rdata, m1_rdata, mem_addr, mem_wd, mem_rd;
  logic [1:0] owner;
  logic b1_m0_gnt, b1_m0_rvalid, b1_m1_gnt, b1_m1_rvalid, b1_mem_we;
  logic [31:0] b1_m0_rdata, b1_m1_rdata, b1_mem_addr, b1_mem_wd;
  logic [1:0] b1_owner;
  logic [31:0] mem [0:255];
  logic [32:0] sb [$];
  bit p0, p1;
  int checks = 0;
  int failures = 0;
  always #5 clk = ~clk;
  mem_port_arbiter dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wd(mem_wd), .mem_rd(mem_rd),
    .owner(owner)
  );
  mem_port_arbiter #(.MAX_BURST(1)) dut_b1 (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(b1_m0_gnt), .m0_rvalid(b1_m0_rvalid), .m0_rdata(b1_m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(b1_m1_gnt), .m1_rvalid(b1_m1_rvalid), .m1_rdata(b1_m1_rdata),
    .mem_we(b1_mem_we), .mem_addr(b1_mem_addr), .mem_wd(b1_mem_wd), .mem_rd(32'h0),
    .owner(b1_owner)
  );
  assign mem_rd = mem[mem_addr[9:2]];
  always @(posedge clk)
    if (rst) for (int k = 0; k < 256; k++) mem[k] <= (k == 4) ? 32'hDEADBEEF : 32'hC0DE0000 + k;
    else if (mem_we) mem[mem_addr[9:2]] <= mem_wd;
  task automatic monitor_step;
    logic [32:0] e, got;
    if (rst) begin
      p0 = 1'b0;
      p1 = 1'b0;
      sb.delete();
    end else begin
      checks++;
      if (m0_rvalid !== p0 || m1_rvalid !== p1) begin
        failures++;
        $display("FAIL sb_rvalid got m0=%b m1=%b exp m0=%b m1=%b t=%0t", m0_rvalid, m1_rvalid, p0, p1, $time);
      end
      if (m0_rvalid === 1'b1 || m1_rvalid === 1'b1) begin
        checks++;
        got = {m1_rvalid, m1_rvalid ? m1_rdata : m0_rdata};
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL sb_empty got %h exp none t=%0t", got, $time);
        end else begin
          e = sb.pop_front();
          if (got !== e) begin
            failures++;
            $display("FAIL sb_rdata got %h exp %h t=%0t", got, e, $time);
          end
        end
      end
      p0 = m0_gnt === 1'b1 && m0_we === 1'b0;
      p1 = m1_gnt === 1'b1 && m1_we === 1'b0;
      if (p0) sb.push_back({1'b0, mem[m0_addr[9:2]]});
      if (p1) sb.push_back({1'b1, mem[m1_addr[9:2]]});
    end
  endtask
  task automatic cyc;
    @(negedge clk);
    monitor_step();
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset;
    rst = 1'b1;
    m0_req = 1'b0;
    m1_req = 1'b0;
    cyc();
    cyc();
    rst = 1'b0;
  endtask
  task automatic test_reset;
    cyc();
    cyc();
    #1;
    checks++;
    if ({owner, m0_gnt, m1_gnt, m0_rvalid, m1_rvalid} !== 6'b0 || m0_rdata !== 32'h0 || m1_rdata !== 32'h0) begin
      failures++;
      $display("FAIL reset_state got owner=%b gnt=%b%b rv=%b%b rd0=%h rd1=%h exp all 0", owner, m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, m0_rdata, m1_rdata);
    end
    rst = 1'b0;
  endtask
  task automatic test_single_read;
    cyc();
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h10;
    #1;
    checks++;
    if (owner !== 2'b00 || m0_gnt !== 1'b0) begin
      failures++;
      $display("FAIL rd_arb got owner=%b gnt=%b exp 00 0", owner, m0_gnt);
    end
    cyc();
    #1;
    checks++;
    if (owner !== 2'b01 || m0_gnt !== 1'b1 || m1_gnt !== 1'b0 || mem_addr !== 32'h10 || mem_we !== 1'b0) begin
      failures++;
      $display("FAIL rd_gnt got owner=%b gnt=%b%b addr=%h we=%b exp 01 10 00000010 0", owner, m0_gnt, m1_gnt, mem_addr, mem_we);
    end
    cyc();
    m0_req = 1'b0;
    #1;
    checks++;
    if (m0_rvalid !== 1'b1 || m0_rdata !== 32'hDEADBEEF || m1_rvalid !== 1'b0 || m1_rdata !== 32'h0) begin
      failures++;
      $display("FAIL rd_data got rv=%b rd=%h m1rv=%b m1rd=%h exp 1 deadbeef 0 0", m0_rvalid, m0_rdata, m1_rvalid, m1_rdata);
    end
    cyc();
    #1;
    checks++;
    if (m0_rvalid !== 1'b0 || owner !== 2'b00) begin
      failures++;
      $display("FAIL rd_pulse got rv=%b owner=%b exp 0 00", m0_rvalid, owner);
    end
  endtask
  task automatic test_tie;
    do_reset();
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h10;
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h14;
    cyc();
    #1;
    checks++;
    if (owner !== 2'b01 || m0_gnt !== 1'b1 || m1_gnt !== 1'b0) begin
      failures++;
      $display("FAIL tie_first got owner=%b gnt=%b%b exp 01 10", owner, m0_gnt, m1_gnt);
    end
    cyc();
    m0_req = 1'b0;
    #1;
    checks++;
    if (owner !== 2'b01 || m0_gnt !== 1'b0 || m1_gnt !== 1'b0) begin
      failures++;
      $display("FAIL tie_drop got owner=%b gnt=%b%b exp 01 00", owner, m0_gnt, m1_gnt);
    end
    cyc();
    #1;
    checks++;
    if (owner !== 2'b10 || m1_gnt !== 1'b1 || m0_gnt !== 1'b0) begin
      failures++;
      $display("FAIL tie_handover got owner=%b gnt=%b%b exp 10 01", owner, m0_gnt, m1_gnt);
    end
    cyc();
    m1_req = 1'b0;
    cyc();
    #1;
    checks++;
    if (owner !== 2'b00) begin
      failures++;
      $display("FAIL tie_idle got owner=%b exp 00", owner);
    end
    m0_req = 1'b1;
    m1_req = 1'b1;
    cyc();
    #1;
    checks++;
    if (owner !== 2'b01 || m0_gnt !== 1'b1 || m1_gnt !== 1'b0) begin
      failures++;
      $display("FAIL tie_second got owner=%b gnt=%b%b exp 01 10", owner, m0_gnt, m1_gnt);
    end
    m0_req = 1'b0;
    m1_req = 1'b0;
    cyc();
    cyc();
  endtask
  task automatic test_burst_writes;
    int i = 0;
    int k = 0;
    int zeros = 0;
    int seq [$];
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h20;
    m1_req = 1'b1; m1_we = 1'b1; m1_addr = 32'h100; m1_wdata = 32'h0;
    while (m1_req && k < 200) begin
      #1;
      seq.push_back(m1_gnt ? 2 : m0_gnt ? 1 : 0);
      if (m1_gnt) i++;
      if (!m1_gnt && !m0_gnt) zeros++;
      cyc();
      k++;
      if (i < 20) begin
        m1_addr = 32'h100 + 32'(4 * i);
        m1_wdata = 32'(i);
      end else m1_req = 1'b0;
    end
    checks++;
    if (i != 20 || zeros != 1) begin
      failures++;
      $display("FAIL burst_done got writes=%0d idle_cycles=%0d exp 20 1", i, zeros);
    end
    for (int j = 0; j < 10 && j < seq.size(); j++) begin
      checks++;
      if (seq[j] != (j == 0 ? 0 : j == 9 ? 1 : 2)) begin
        failures++;
        $display("FAIL burst_seq[%0d] got %0d exp %0d", j, seq[j], j == 0 ? 0 : j == 9 ? 1 : 2);
      end
    end
    m0_req = 1'b0;
    cyc();
    cyc();
    cyc();
    for (int j = 0; j < 20; j++) begin
      checks++;
      if (mem[8'h40 + j] !== 32'(j)) begin
        failures++;
        $display("FAIL burst_mem[%0d] got %h exp %h", j, mem[8'h40 + j], 32'(j));
      end
    end
  endtask
  task automatic test_m0_stream;
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h200;
    cyc();
    for (int k = 0; k < 12; k++) begin
      #1;
      checks++;
      if (m0_gnt !== 1'b1 || owner !== 2'b01) begin
        failures++;
        $display("FAIL stream_gnt[%0d] got gnt=%b owner=%b exp 1 01", k, m0_gnt, owner);
      end
      if (k > 0) begin
        checks++;
        if (m0_rvalid !== 1'b1 || m0_rdata !== 32'hC0DE0080 + 32'(k - 1)) begin
          failures++;
          $display("FAIL stream_rd[%0d] got rv=%b rd=%h exp 1 %h", k, m0_rvalid, m0_rdata, 32'hC0DE0080 + 32'(k - 1));
        end
      end
      cyc();
      m0_addr = 32'h200 + 32'(4 * (k + 1));
    end
    m0_req = 1'b0;
    cyc();
    cyc();
  endtask
  task automatic test_reset_mid;
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h10;
    cyc();
    #1;
    checks++;
    if (m0_gnt !== 1'b1) begin
      failures++;
      $display("FAIL mid_gnt got %b exp 1", m0_gnt);
    end
    #1;
    rst = 1'b1;
    m0_req = 1'b0;
    #1;
    checks++;
    if ({owner, m0_gnt, m1_gnt, m0_rvalid, m1_rvalid} !== 6'b0 || m0_rdata !== 32'h0 || m1_rdata !== 32'h0) begin
      failures++;
      $display("FAIL mid_async got owner=%b gnt=%b%b rv=%b%b rd0=%h rd1=%h exp all 0", owner, m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, m0_rdata, m1_rdata);
    end
    cyc();
    #1;
    checks++;
    if (m0_rvalid !== 1'b0 || owner !== 2'b00) begin
      failures++;
      $display("FAIL mid_norv got rv=%b owner=%b exp 0 00", m0_rvalid, owner);
    end
    cyc();
    rst = 1'b0;
    cyc();
    #1;
    checks++;
    if (m0_rvalid !== 1'b0 || owner !== 2'b00) begin
      failures++;
      $display("FAIL mid_after got rv=%b owner=%b exp 0 00", m0_rvalid, owner);
    end
  endtask
  task automatic test_burst1;
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h10;
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h14;
    cyc();
    for (int k = 0; k < 8; k++) begin
      #1;
      checks++;
      if (b1_m0_gnt !== 1'((k % 2) == 0) || b1_m1_gnt !== 1'((k % 2) == 1)) begin
        failures++;
        $display("FAIL b1_alt[%0d] got gnt=%b%b exp %b%b", k, b1_m0_gnt, b1_m1_gnt, 1'((k % 2) == 0), 1'((k % 2) == 1));
      end
      cyc();
    end
    m0_req = 1'b0;
    m1_req = 1'b0;
    cyc();
    cyc();
    cyc();
  endtask
  initial begin
    test_reset();
    test_single_read();
    test_tie();
    test_burst_writes();
    test_m0_stream();
    test_reset_mid();
    test_burst1();
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL sb_leftover got %0d exp 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL timeout got running exp finished");
    $fatal(1, "timeout");
  end
endmodule
